// File: rtl/pwm_duty_meas.sv
// ----------------------------------------------------------------------------
// pwm_duty_meas
//
// Receive-side PWM measurement. Samples an asynchronous PWM input, measures
// the high time and the rising-to-rising period in clk cycles, and publishes
// both with a one-cycle strobe. A stuck or missing input is reported through
// a timeout that repeats every TIMEOUT+1 cycles while the input stays stuck.
//
// Handshake: meas_vld is a one-cycle strobe with no back-pressure. duty,
// period and timeout change only in the cycle meas_vld is high and hold
// their values until the next strobe. A consumer must capture on the strobe.
//
// Optional build macro: PWM_GLITCH_FILT_EN
//   Defined   - a 3-sample level filter sits between the synchronizer and
//               the edge detector. Pulses or gaps shorter than 3 clks are
//               ignored. Pin-to-edge latency is 5 clks.
//   Undefined - every synchronized transition is an edge. Pin-to-edge
//               latency is 3 clks.
//
// Parameters:
//   WIDTH   - duty width; duty saturates at 2^WIDTH-1
//   PER_W   - period counter/output width
//   TIMEOUT - cycles without a completed period before a timeout report
//             (must be < 2^PER_W)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   pwm_in    in   asynchronous PWM input
//   duty      out  last measured high time in clks (saturated)
//   period    out  last measured period in clks (rising to rising)
//   meas_vld  out  one-cycle strobe: duty/period/timeout updated this cycle
//   timeout   out  level; 1 = last report was a timeout
//   dbg_state out  current measurement FSM state (0=SYNC, 1=HIGH, 2=LOW)
// ----------------------------------------------------------------------------
module pwm_duty_meas #(
  parameter int WIDTH   = 11,
  parameter int PER_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [PER_W-1:0] period,
  output logic             meas_vld,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [PER_W-1:0] TO_VAL  = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [WIDTH-1:0] HI_ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] hi_cnt;
  logic [PER_W-1:0] per_cnt;

  // --------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // --------------------------------------------------------------------------
  logic sync1;
  logic pwm_s;
  logic pwm_d;
  logic rise;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

`ifdef PWM_GLITCH_FILT_EN
  // Filtered level follows pwm_s only once three consecutive samples agree.
  // The edge is taken from the filter's next value against its current
  // value, so an edge is seen in the same cycle the filter flips.
  logic pwm_d2;
  logic filt;
  logic filt_nxt;

  always_comb begin
    filt_nxt = filt;
    if (pwm_s & pwm_d & pwm_d2)
      filt_nxt = 1'b1;
    else if (~(pwm_s | pwm_d | pwm_d2))
      filt_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_d2 <= 1'b0;
      filt   <= 1'b0;
    end else begin
      pwm_d2 <= pwm_d;
      filt   <= filt_nxt;
    end
  end

  assign rise = filt_nxt & ~filt;
  assign fall = ~filt_nxt & filt;
`else
  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;
`endif

  // --------------------------------------------------------------------------
  // Measurement FSM
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] hi_inc;
  logic [PER_W-1:0] per_inc;
  logic             to_hit;

  // hi_cnt saturates so very long high phases report full-scale duty.
  assign hi_inc  = (&hi_cnt) ? hi_cnt : hi_cnt + HI_ONE;
  assign per_inc = per_cnt + PER_ONE;
  // A rise in the timeout cycle completes a normal period and wins.
  assign to_hit  = (per_cnt == TO_VAL) && !rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SYNC;
      hi_cnt   <= '0;
      per_cnt  <= '0;
      duty     <= '0;
      period   <= '0;
      meas_vld <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      if (to_hit) begin
        // Stuck input: report the current level as 0% or 100% duty.
        meas_vld <= 1'b1;
        timeout  <= 1'b1;
        period   <= TO_VAL;
        duty     <= pwm_s ? '1 : '0;
        per_cnt  <= '0;
        hi_cnt   <= '0;
        state    <= ST_SYNC;
      end else begin
        case (state)
          ST_SYNC: begin
            if (rise) begin
              hi_cnt  <= HI_ONE;
              per_cnt <= PER_ONE;
              state   <= ST_HIGH;
            end else begin
              per_cnt <= per_inc;
            end
          end
          ST_HIGH: begin
            per_cnt <= per_inc;
            if (fall)
              state <= ST_LOW;
            else
              hi_cnt <= hi_inc;
          end
          ST_LOW: begin
            if (rise) begin
              // A full period has completed; the rise also starts the next.
              duty     <= hi_cnt;
              period   <= per_cnt;
              timeout  <= 1'b0;
              meas_vld <= 1'b1;
              hi_cnt   <= HI_ONE;
              per_cnt  <= PER_ONE;
              state    <= ST_HIGH;
            end else begin
              per_cnt <= per_inc;
            end
          end
          default: begin
            state <= ST_SYNC;
          end
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// ----------------------------------------------------------------------------
// tb_pwm_duty_meas
//
// Self-checking bench for pwm_duty_meas. Drivers push the expected report of
// every completed period (or timeout) into exp_q; a monitor pops and compares
// on each meas_vld and checks that outputs hold between reports.
// ----------------------------------------------------------------------------
module tb_pwm_duty_meas;

  localparam int WIDTH   = 11;
  localparam int PER_W   = 12;
  localparam int TIMEOUT = 4095;
  localparam int W       = 1 + WIDTH + PER_W;
  localparam int DMAX    = (1 << WIDTH) - 1;

  // Clock / reset
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pwm_in = 1'b0;

  logic [WIDTH-1:0] duty;
  logic [PER_W-1:0] period;
  logic             meas_vld;
  logic             timeout;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  pwm_duty_meas #(
    .WIDTH  (WIDTH),
    .PER_W  (PER_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .duty     (duty),
    .period   (period),
    .meas_vld (meas_vld),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   last_rep = '0;
  bit             prev_valid = 0;
  int             prev_h = 0;
  int             prev_l = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit t, input int d, input int p);
    int ds;
    ds = (d > DMAX) ? DMAX : d;
    return {t, ds[WIDTH-1:0], p[PER_W-1:0]};
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (meas_vld) begin
        chk("q_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("meas", 32'({timeout, duty, period}), 32'(e));
          last_rep = e;
        end
      end else begin
        chk("hold", 32'({timeout, duty, period}), 32'(last_rep));
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    chk("q_drain", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    pwm_in     = 1'b0;
    last_rep   = '0;
    prev_valid = 0;
    #1;
    chk("rst_out", 32'({meas_vld, timeout, duty, period}), 0);
    chk("rst_state", 32'(dbg_state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One PWM period: the rise that starts it completes the previous period.
  task automatic pulse(input int h, input int l);
    if (prev_valid) exp_q.push_back(pack(0, prev_h, prev_h + prev_l));
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
    prev_h     = h;
    prev_l     = l;
    prev_valid = 1;
  endtask

  // Closing rise so the last driven period gets reported.
  task automatic finish_train();
    if (prev_valid) exp_q.push_back(pack(0, prev_h, prev_h + prev_l));
    prev_valid = 0;
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int first;
    int second;

    do_reset();

    // Nominal 25% duty, full 2048-cycle period
    repeat (3) pulse(512, 1536);
    finish_train();
    do_reset();

    // High time beyond duty range saturates
    repeat (2) pulse(3000, 500);
    finish_train();
    do_reset();

    // Stuck low after reset, then a normal PWM
    exp_q.push_back(pack(1, 0, TIMEOUT));
    exp_q.push_back(pack(1, 0, TIMEOUT));
    first  = -1;
    second = -1;
    for (int i = 1; i <= 10000; i++) begin
      @(negedge clk);
      if (meas_vld) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("to_first", first, TIMEOUT + 1);
    chk("to_gap", second - first, TIMEOUT + 1);
    repeat (2) pulse(100, 100);
    finish_train();
    do_reset();

    // Stuck high
    exp_q.push_back(pack(1, DMAX, TIMEOUT));
    exp_q.push_back(pack(1, DMAX, TIMEOUT));
    pwm_in = 1'b1;
    repeat (9000) @(negedge clk);
    do_reset();

    // Reset in the middle of a high phase discards the partial period
    repeat (2) pulse(1024, 1024);
    exp_q.push_back(pack(0, 1024, 2048));
    prev_valid = 0;
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    do_reset();
    repeat (2) pulse(1024, 1024);
    finish_train();
    do_reset();

    // 2-clk low glitch inside a 600-clk high phase
`ifdef PWM_GLITCH_FILT_EN
    exp_q.push_back(pack(0, 600, 1600));
`else
    exp_q.push_back(pack(0, 300, 302));
    exp_q.push_back(pack(0, 298, 1298));
`endif
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pwm_in = 1'b1;
    repeat (298) @(negedge clk);
    pwm_in = 1'b0;
    repeat (1000) @(negedge clk);
    finish_train();
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
